// File: rtl/ntt_stream_stager.sv
// Stream front/back end for an NTT core: buffers N input coefficients, serves the
// NTT read port, captures NTT results and streams them out over valid/ready.
module ntt_stream_stager #(
    parameter int LOGN = 12,
    parameter int LOGQ = 64,
    parameter int AW   = (LOGN < 9) ? 10 : LOGN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            intt_mode,
    input  logic [LOGQ-1:0] q_in,
    input  logic [LOGQ-1:0] s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [LOGQ-1:0] m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_last,
    output logic            ntt_start,
    output logic            ntt_intt,
    output logic [LOGQ-1:0] ntt_q,
    input  logic [AW-1:0]   ntt_read_address,
    output logic [LOGQ-1:0] ntt_data_in,
    input  logic [AW-1:0]   ntt_write_address,
    input  logic            ntt_wea,
    input  logic [LOGQ-1:0] ntt_data_out,
    input  logic            ntt_finish,
    output logic            busy,
    output logic            err,
    output logic            done
);
    localparam int N = 1 << LOGN;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t          state_reg, state_next;
    logic [LOGN-1:0] cnt_reg, cnt_next;
    logic            start_reg, start_next;
    logic            m_valid_reg, m_valid_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;
    logic            intt_reg, intt_next;
    logic [LOGQ-1:0] q_reg, q_next;
    logic            finish_d_reg;
    logic [LOGQ-1:0] m_data_reg;
    logic [LOGQ-1:0] data_in_reg;

    logic [LOGQ-1:0] input_buf  [N];
    logic [LOGQ-1:0] output_buf [N];

    logic            s_hs;
    logic            m_hs;
    logic            cnt_last;
    logic            finish_rise;
    logic            over_q;
    logic [LOGQ-1:0] q_eff;
    logic [LOGQ-1:0] in_word;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr;
    logic            unused_addr_bits;

    // The modulus is not yet registered on the very first handshake of a frame.
    assign q_eff       = (state_reg == IDLE) ? q_in : q_reg;
    assign over_q      = (s_data >= q_eff);
    assign in_word     = over_q ? (s_data - q_eff) : s_data;
    assign s_ready     = (state_reg == IDLE) || (state_reg == LOAD);
    assign s_hs        = s_valid && s_ready;
    assign m_hs        = m_valid_reg && m_ready;
    assign cnt_last    = (cnt_reg == LOGN'(N - 1));
    assign finish_rise = ntt_finish && !finish_d_reg;

    // While a word is presented, fetch the one after it so a handshake never bubbles.
    assign rd_en   = (state_reg == DRAIN) && (!m_valid_reg || m_ready);
    assign rd_addr = m_valid_reg ? (cnt_reg + LOGN'(1)) : cnt_reg;

    assign unused_addr_bits = ^{ntt_read_address, ntt_write_address};

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        start_next   = start_reg;
        m_valid_next = m_valid_reg;
        done_next    = 1'b0;
        intt_next    = intt_reg;
        q_next       = q_reg;
        err_next     = err_reg || (s_hs && over_q);
        case (state_reg)
            IDLE: begin
                if (s_hs) begin
                    intt_next  = intt_mode;
                    q_next     = q_in;
                    cnt_next   = LOGN'(1);
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (s_hs) begin
                    cnt_next = cnt_reg + LOGN'(1);
                    if (cnt_last) begin
                        cnt_next   = '0;
                        start_next = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (finish_rise) begin
                    start_next = 1'b0;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!m_valid_reg) begin
                    m_valid_next = 1'b1;
                end else if (m_ready) begin
                    if (cnt_last) begin
                        m_valid_next = 1'b0;
                        done_next    = 1'b1;
                        cnt_next     = '0;
                        state_next   = IDLE;
                    end else begin
                        cnt_next = cnt_reg + LOGN'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            start_reg    <= 1'b0;
            m_valid_reg  <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            intt_reg     <= 1'b0;
            q_reg        <= '0;
            finish_d_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            start_reg    <= start_next;
            m_valid_reg  <= m_valid_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            intt_reg     <= intt_next;
            q_reg        <= q_next;
            finish_d_reg <= ntt_finish;
        end
    end

    always_ff @(posedge clk) begin
        if (s_hs) begin
            input_buf[cnt_reg] <= in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_in_reg <= '0;
        end else begin
            data_in_reg <= input_buf[ntt_read_address[LOGN-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if ((state_reg == RUN) && ntt_wea) begin
            output_buf[ntt_write_address[LOGN-1:0]] <= ntt_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            m_data_reg <= output_buf[rd_addr];
        end
    end

    assign m_data      = m_data_reg;
    assign m_valid     = m_valid_reg;
    assign m_last      = m_valid_reg && cnt_last;
    assign ntt_start   = start_reg;
    assign ntt_intt    = intt_reg;
    assign ntt_q       = q_reg;
    assign ntt_data_in = data_in_reg;
    assign busy        = (state_reg != IDLE);
    assign err         = err_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_ntt_stream_stager.sv
// Randomized self-checking bench for ntt_stream_stager (N=16) with a stub NTT
// and a reference model of buffer contents, error flag and output stream.
module tb_ntt_stream_stager;
    localparam int LOGN = 4;
    localparam int LOGQ = 16;
    localparam int AW   = 10;
    localparam int N    = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            intt_mode = 1'b0;
    logic [LOGQ-1:0] q_in = '0;
    logic [LOGQ-1:0] s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [LOGQ-1:0] m_data;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic            m_last;
    logic            ntt_start;
    logic            ntt_intt;
    logic [LOGQ-1:0] ntt_q;
    logic [AW-1:0]   rd_addr = '0;
    logic [LOGQ-1:0] ntt_data_in;
    logic [AW-1:0]   wr_addr = '0;
    logic            wea = 1'b0;
    logic [LOGQ-1:0] dout = '0;
    logic            finish = 1'b0;
    logic            busy;
    logic            err;
    logic            done;

    ntt_stream_stager #(.LOGN(LOGN), .LOGQ(LOGQ)) dut (
        .clk(clk), .rst(rst), .intt_mode(intt_mode), .q_in(q_in),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .ntt_start(ntt_start), .ntt_intt(ntt_intt), .ntt_q(ntt_q),
        .ntt_read_address(rd_addr), .ntt_data_in(ntt_data_in),
        .ntt_write_address(wr_addr), .ntt_wea(wea), .ntt_data_out(dout),
        .ntt_finish(finish), .busy(busy), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [LOGQ-1:0] words   [N];
    logic [LOGQ-1:0] exp_in  [N];
    logic [LOGQ-1:0] exp_out [N];
    logic            exp_err = 1'b0;
    logic            err_after [N];

    // Drain observations
    logic [LOGQ-1:0] got_q[$];
    bit              got_last[$];
    int              done_cnt, hold_viol, first_valid;
    bit              drain_timeout, busy_after, s_ready_after;

    task automatic do_load(input bit mode, input logic [LOGQ-1:0] q, input int finish_at);
        for (int i = 0; i < N; i++) begin
            s_valid   = 1'b1;
            s_data    = words[i];
            intt_mode = mode;
            q_in      = q;
            finish    = (i == finish_at);
            exp_in[i] = (words[i] >= q) ? words[i] - q : words[i];
            if (words[i] >= q) exp_err = 1'b1;
            @(posedge clk); #1;
            err_after[i] = err;
        end
        s_valid   = 1'b0;
        finish    = 1'b0;
        intt_mode = ~mode;
        q_in      = LOGQ'($urandom);
    endtask

    // Stub NTT: writes every result in a scrambled order; finish rises with the last write.
    task automatic do_stub();
        for (int i = 0; i < N; i++) begin
            int a;
            a       = (i * 7) % N;
            wea     = 1'b1;
            wr_addr = (AW'($urandom) & 10'h3F0) | AW'(a);
            dout    = exp_out[a];
            finish  = (i == N - 1);
            @(posedge clk); #1;
        end
        wea = 1'b0;
    endtask

    task automatic do_drain(input int pattern);
        int k;
        bit pend;
        logic [LOGQ-1:0] held;
        int pat[4] = '{1, 0, 0, 1};
        got_q.delete();
        got_last.delete();
        done_cnt = 0; hold_viol = 0; first_valid = -1; pend = 0; held = '0; k = 0;
        while (got_q.size() < N && k < 300) begin
            case (pattern)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[k % 4][0];
                default: m_ready = $urandom_range(0, 1) == 1;
            endcase
            // A write outside RUN must not reach the output buffer.
            wea     = (k == 0);
            wr_addr = AW'(5);
            dout    = 16'hdead;
            if (k == 5) finish = 1'b0;
            if (pend && (m_valid !== 1'b1 || m_data !== held)) hold_viol++;
            pend = (m_valid === 1'b1) && !m_ready;
            held = m_data;
            if (m_valid === 1'b1 && first_valid < 0) first_valid = k;
            if (done === 1'b1) done_cnt++;
            if (m_valid === 1'b1 && m_ready) begin
                got_q.push_back(m_data);
                got_last.push_back(m_last);
            end
            @(posedge clk); #1;
            k++;
        end
        wea = 1'b0; finish = 1'b0; m_ready = 1'b0;
        drain_timeout = (k >= 300);
        if (done === 1'b1) done_cnt++;
        busy_after    = busy;
        s_ready_after = s_ready;
        @(posedge clk); #1;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err = 1'b0;
        checks++;
        if ({s_ready, m_valid, m_last, ntt_start, ntt_intt, busy, err, done} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 10000000",
                     {s_ready, m_valid, m_last, ntt_start, ntt_intt, busy, err, done});
        end
        checks++;
        if (ntt_q !== '0 || ntt_data_in !== '0) begin
            failures++;
            $display("FAIL reset_data: got q=%0d data_in=%0d expected 0 0", ntt_q, ntt_data_in);
        end
    endtask

    task automatic test_load_and_read();
        for (int i = 0; i < N; i++) words[i] = LOGQ'(i);
        do_load(1'b0, 16'd7681, -1);
        checks++;
        if ({ntt_start, s_ready, busy, ntt_intt, err} !== 5'b10100) begin
            failures++;
            $display("FAIL start_after_load: got start,ready,busy,intt,err=%b expected 10100",
                     {ntt_start, s_ready, busy, ntt_intt, err});
        end
        checks++;
        if (ntt_q !== 16'd7681) begin
            failures++;
            $display("FAIL ntt_q_latched: got %0d expected 7681", ntt_q);
        end
        rd_addr = AW'(5);
        @(posedge clk); #1;
        checks++;
        if (ntt_data_in !== exp_in[5]) begin
            failures++;
            $display("FAIL read_addr5: got %0d expected %0d", ntt_data_in, exp_in[5]);
        end
        for (int r = 0; r < 6; r++) begin
            int a;
            a       = $urandom_range(0, N - 1);
            rd_addr = (AW'($urandom) & 10'h3F0) | AW'(a);
            @(posedge clk); #1;
            checks++;
            if (ntt_data_in !== exp_in[a]) begin
                failures++;
                $display("FAIL read_random: addr %0d got %0d expected %0d", a, ntt_data_in, exp_in[a]);
            end
        end
        checks++;
        if (ntt_start !== 1'b1 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL start_held: got start=%b ready=%b expected 1 0", ntt_start, s_ready);
        end
    endtask

    task automatic test_finish_and_drain();
        for (int i = 0; i < N; i++) exp_out[i] = LOGQ'(100 + i);
        do_stub();
        checks++;
        if ({ntt_start, busy, m_valid} !== 3'b010) begin
            failures++;
            $display("FAIL finish_edge: got start,busy,m_valid=%b expected 010", {ntt_start, busy, m_valid});
        end
        do_drain(0);
        checks++;
        if (drain_timeout || got_q.size() != N) begin
            failures++;
            $display("FAIL drain_count: got %0d words expected %0d", got_q.size(), N);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_out[i] || got_last[i] !== (i == N - 1)) begin
                failures++;
                $display("FAIL drain_word%0d: got %0d last=%0d expected %0d last=%0d",
                         i, got_q[i], got_last[i], exp_out[i], i == N - 1);
            end
        end
        checks++;
        if (first_valid != 1) begin
            failures++;
            $display("FAIL prefetch_latency: got first valid at cycle %0d expected 1", first_valid);
        end
        checks++;
        if (done_cnt != 1 || busy_after !== 1'b0 || s_ready_after !== 1'b1) begin
            failures++;
            $display("FAIL frame_end: got done=%0d busy=%b ready=%b expected 1 0 1",
                     done_cnt, busy_after, s_ready_after);
        end
    endtask

    task automatic test_range_check();
        for (int i = 0; i < N; i++) words[i] = LOGQ'($urandom_range(0, 7680));
        words[3] = 16'd7690;
        do_load(1'b1, 16'd7681, -1);
        checks++;
        if (err_after[2] !== 1'b0 || err_after[3] !== 1'b1 || err_after[15] !== 1'b1) begin
            failures++;
            $display("FAIL err_timing: got %b%b%b expected 011", err_after[2], err_after[3], err_after[15]);
        end
        checks++;
        if (ntt_intt !== 1'b1 || ntt_q !== 16'd7681) begin
            failures++;
            $display("FAIL mode_latched: got intt=%b q=%0d expected 1 7681", ntt_intt, ntt_q);
        end
        for (int a = 0; a < N; a++) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            checks++;
            if (ntt_data_in !== exp_in[a]) begin
                failures++;
                $display("FAIL range_buf%0d: got %0d expected %0d", a, ntt_data_in, exp_in[a]);
            end
        end
        for (int i = 0; i < N; i++) exp_out[i] = LOGQ'($urandom);
        do_stub();
        do_drain(1);
        checks++;
        if (drain_timeout || got_q.size() != N || hold_viol != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL toggle_drain: got words=%0d holdviol=%0d done=%0d expected %0d 0 1",
                     got_q.size(), hold_viol, done_cnt, N);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_out[i] || got_last[i] !== (i == N - 1)) begin
                failures++;
                $display("FAIL toggle_word%0d: got %0d expected %0d", i, got_q[i], exp_out[i]);
            end
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < N; i++) words[i] = LOGQ'($urandom_range(0, 12288));
        do_load(1'b0, 16'd12289, -1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 1'b0;
        checks++;
        if ({ntt_start, busy, s_ready, err, m_valid} !== 5'b00100) begin
            failures++;
            $display("FAIL reset_mid_run: got start,busy,ready,err,m_valid=%b expected 00100",
                     {ntt_start, busy, s_ready, err, m_valid});
        end
        for (int i = 0; i < N; i++) words[i] = LOGQ'($urandom);
        do_load(1'b1, LOGQ'($urandom_range(30000, 65535)), 8);
        checks++;
        if (ntt_start !== 1'b1 || err !== exp_err) begin
            failures++;
            $display("FAIL reload_after_reset: got start=%b err=%b expected 1 %b", ntt_start, err, exp_err);
        end
        for (int i = 0; i < N; i++) exp_out[i] = LOGQ'($urandom);
        do_stub();
        do_drain(2);
        checks++;
        if (drain_timeout || got_q.size() != N || hold_viol != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL post_reset_drain: got words=%0d holdviol=%0d done=%0d expected %0d 0 1",
                     got_q.size(), hold_viol, done_cnt, N);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_out[i]) begin
                failures++;
                $display("FAIL post_reset_word%0d: got %0d expected %0d", i, got_q[i], exp_out[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            bit mode;
            logic [LOGQ-1:0] q;
            mode = $urandom_range(0, 1) == 1;
            q    = LOGQ'($urandom_range(20000, 65535));
            for (int i = 0; i < N; i++) words[i] = LOGQ'($urandom);
            do_load(mode, q, -1);
            checks++;
            if (ntt_intt !== mode || ntt_q !== q || err !== exp_err) begin
                failures++;
                $display("FAIL b2b_params%0d: got intt=%b q=%0d err=%b expected %b %0d %b",
                         f, ntt_intt, ntt_q, err, mode, q, exp_err);
            end
            rd_addr = AW'($urandom);
            @(posedge clk); #1;
            checks++;
            if (ntt_data_in !== exp_in[rd_addr[LOGN-1:0]]) begin
                failures++;
                $display("FAIL b2b_read%0d: got %0d expected %0d", f, ntt_data_in, exp_in[rd_addr[LOGN-1:0]]);
            end
            for (int i = 0; i < N; i++) exp_out[i] = LOGQ'($urandom);
            do_stub();
            do_drain(2);
            checks++;
            if (drain_timeout || got_q.size() != N || hold_viol != 0 || done_cnt != 1) begin
                failures++;
                $display("FAIL b2b_drain%0d: got words=%0d holdviol=%0d done=%0d expected %0d 0 1",
                         f, got_q.size(), hold_viol, done_cnt, N);
            end
            for (int i = 0; i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_out[i] || got_last[i] !== (i == N - 1)) begin
                    failures++;
                    $display("FAIL b2b%0d_word%0d: got %0d expected %0d", f, i, got_q[i], exp_out[i]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_load_and_read();
        test_finish_and_drain();
        test_range_check();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
